// File: rtl/rep_sequencer_pkg.sv
// Shared types and helpers for the REP string-instruction sequencer.
package rep_sequencer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } rep_state_e;

    localparam logic [1:0] OPSZ_1B = 2'b00;
    localparam logic [1:0] OPSZ_2B = 2'b01;
    localparam logic [1:0] OPSZ_4B = 2'b10;
    localparam logic [1:0] OPSZ_8B = 2'b11;

    // Byte stride of one string element for a given operand-size code.
    function automatic logic [3:0] opsize_step(input logic [1:0] opsize);
        case (opsize)
            OPSZ_1B: return 4'd1;
            OPSZ_2B: return 4'd2;
            OPSZ_4B: return 4'd4;
            OPSZ_8B: return 4'd8;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/rep_sequencer_addr_step.sv
// Address stepper: addr +/- element size, wrapping modulo 2^ADDR_WIDTH.
module rep_addr_step
    import rep_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [1:0]            opsize_in,
    input  logic                  df_in,
    output logic [ADDR_WIDTH-1:0] addr_out
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] delta;

    // Decrementing is done by adding the two's-complement of the stride.
    always_comb begin
        step     = ADDR_WIDTH'(opsize_step(opsize_in));
        delta    = df_in ? (~step + ADDR_WIDTH'(1)) : step;
        addr_out = addr_in + delta;
    end

endmodule

// File: rtl/rep_sequencer.sv
// Expands REP-prefixed string instructions into one memory micro-op per
// iteration; non-REP instructions pass through with one cycle of latency.
module rep_sequencer
    import rep_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic                  rep_in,
    input  logic                  df_in,
    input  logic [1:0]            opsize_in,
    input  logic [ADDR_WIDTH-1:0] mem_addr1_in,
    input  logic [ADDR_WIDTH-1:0] mem_addr2_in,
    input  logic [1:0]            mem1_rw_in,
    input  logic [1:0]            mem2_rw_in,
    input  logic [CNT_WIDTH-1:0]  rep_num_in,
    input  logic [6:0]            inst_ptcid_in,
    input  logic                  stall_in,
    output logic                  stall_out,
    output logic                  valid_out,
    output logic [1:0]            opsize_out,
    output logic [ADDR_WIDTH-1:0] mem_addr1_out,
    output logic [ADDR_WIDTH-1:0] mem_addr2_out,
    output logic [1:0]            mem1_rw_out,
    output logic [1:0]            mem2_rw_out,
    output logic [CNT_WIDTH-1:0]  rem_count_out,
    output logic                  last_out,
    output logic                  zero_iter_out,
    output logic [6:0]            inst_ptcid_out
);

    // Iteration context saved on entry to ITER
    rep_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
    logic [ADDR_WIDTH-1:0] addr2_q, addr2_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [1:0]            opsize_q, opsize_d;
    logic                  df_q, df_d;
    logic [1:0]            rw1_q, rw1_d;
    logic [1:0]            rw2_q, rw2_d;
    logic [6:0]            tag_q, tag_d;

    // Output register bank
    logic                  valid_out_q, valid_out_d;
    logic [1:0]            opsize_out_q, opsize_out_d;
    logic [ADDR_WIDTH-1:0] addr1_out_q, addr1_out_d;
    logic [ADDR_WIDTH-1:0] addr2_out_q, addr2_out_d;
    logic [1:0]            rw1_out_q, rw1_out_d;
    logic [1:0]            rw2_out_q, rw2_out_d;
    logic [CNT_WIDTH-1:0]  rem_out_q, rem_out_d;
    logic                  last_out_q, last_out_d;
    logic                  zero_out_q, zero_out_d;
    logic [6:0]            tag_out_q, tag_out_d;

    logic                  kill;
    logic                  acc;
    logic                  out_le;
    logic [ADDR_WIDTH-1:0] addr1_nxt;
    logic [ADDR_WIDTH-1:0] addr2_nxt;

    rep_addr_step #(.ADDR_WIDTH(ADDR_WIDTH)) u_step1 (
        .addr_in   (addr1_q),
        .opsize_in (opsize_q),
        .df_in     (df_q),
        .addr_out  (addr1_nxt)
    );

    rep_addr_step #(.ADDR_WIDTH(ADDR_WIDTH)) u_step2 (
        .addr_in   (addr2_q),
        .opsize_in (opsize_q),
        .df_in     (df_q),
        .addr_out  (addr2_nxt)
    );

    assign kill   = clr | flush;
    assign acc    = valid_in & ~stall_in & (state_q == ST_IDLE);
    assign out_le = ~stall_in | kill;

    // Hold upstream while expanding, or when a multi-iteration REP is about to start.
    assign stall_out = ~kill & (stall_in | (state_q == ST_ITER) |
                                ((state_q == ST_IDLE) & valid_in & rep_in &
                                 (rep_num_in > CNT_WIDTH'(1))));

    // Next-state and next-output computation; everything holds by default.
    always_comb begin
        state_d      = state_q;
        addr1_d      = addr1_q;
        addr2_d      = addr2_q;
        cnt_d        = cnt_q;
        opsize_d     = opsize_q;
        df_d         = df_q;
        rw1_d        = rw1_q;
        rw2_d        = rw2_q;
        tag_d        = tag_q;
        valid_out_d  = valid_out_q;
        opsize_out_d = opsize_out_q;
        addr1_out_d  = addr1_out_q;
        addr2_out_d  = addr2_out_q;
        rw1_out_d    = rw1_out_q;
        rw2_out_d    = rw2_out_q;
        rem_out_d    = rem_out_q;
        last_out_d   = last_out_q;
        zero_out_d   = zero_out_q;
        tag_out_d    = tag_out_q;

        if (kill) begin
            state_d      = ST_IDLE;
            addr1_d      = '0;
            addr2_d      = '0;
            cnt_d        = '0;
            opsize_d     = '0;
            df_d         = 1'b0;
            rw1_d        = '0;
            rw2_d        = '0;
            tag_d        = '0;
            valid_out_d  = 1'b0;
            opsize_out_d = '0;
            addr1_out_d  = '0;
            addr2_out_d  = '0;
            rw1_out_d    = '0;
            rw2_out_d    = '0;
            rem_out_d    = '0;
            last_out_d   = 1'b0;
            zero_out_d   = 1'b0;
            tag_out_d    = '0;
        end else if (out_le) begin
            if (state_q == ST_IDLE) begin
                if (acc) begin
                    valid_out_d  = 1'b1;
                    opsize_out_d = opsize_in;
                    addr1_out_d  = mem_addr1_in;
                    addr2_out_d  = mem_addr2_in;
                    rw1_out_d    = mem1_rw_in;
                    rw2_out_d    = mem2_rw_in;
                    tag_out_d    = inst_ptcid_in;
                    rem_out_d    = '0;
                    last_out_d   = 1'b1;
                    zero_out_d   = 1'b0;
                    if (rep_in) begin
                        if (rep_num_in == '0) begin
                            zero_out_d = 1'b1;
                            rw1_out_d  = 2'b00;
                            rw2_out_d  = 2'b00;
                        end else begin
                            rem_out_d  = rep_num_in - CNT_WIDTH'(1);
                            last_out_d = (rep_num_in == CNT_WIDTH'(1));
                            if (rep_num_in != CNT_WIDTH'(1)) begin
                                state_d  = ST_ITER;
                                addr1_d  = mem_addr1_in;
                                addr2_d  = mem_addr2_in;
                                cnt_d    = rep_num_in - CNT_WIDTH'(1);
                                opsize_d = opsize_in;
                                df_d     = df_in;
                                rw1_d    = mem1_rw_in;
                                rw2_d    = mem2_rw_in;
                                tag_d    = inst_ptcid_in;
                            end
                        end
                    end
                end else begin
                    valid_out_d = 1'b0;
                    last_out_d  = 1'b0;
                    zero_out_d  = 1'b0;
                end
            end else begin
                addr1_d      = addr1_nxt;
                addr2_d      = addr2_nxt;
                cnt_d        = cnt_q - CNT_WIDTH'(1);
                valid_out_d  = 1'b1;
                opsize_out_d = opsize_q;
                addr1_out_d  = addr1_nxt;
                addr2_out_d  = addr2_nxt;
                rw1_out_d    = rw1_q;
                rw2_out_d    = rw2_q;
                tag_out_d    = tag_q;
                rem_out_d    = cnt_q - CNT_WIDTH'(1);
                last_out_d   = (cnt_q == CNT_WIDTH'(1));
                zero_out_d   = 1'b0;
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // State, context and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            addr1_q      <= '0;
            addr2_q      <= '0;
            cnt_q        <= '0;
            opsize_q     <= '0;
            df_q         <= 1'b0;
            rw1_q        <= '0;
            rw2_q        <= '0;
            tag_q        <= '0;
            valid_out_q  <= 1'b0;
            opsize_out_q <= '0;
            addr1_out_q  <= '0;
            addr2_out_q  <= '0;
            rw1_out_q    <= '0;
            rw2_out_q    <= '0;
            rem_out_q    <= '0;
            last_out_q   <= 1'b0;
            zero_out_q   <= 1'b0;
            tag_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr1_q      <= addr1_d;
            addr2_q      <= addr2_d;
            cnt_q        <= cnt_d;
            opsize_q     <= opsize_d;
            df_q         <= df_d;
            rw1_q        <= rw1_d;
            rw2_q        <= rw2_d;
            tag_q        <= tag_d;
            valid_out_q  <= valid_out_d;
            opsize_out_q <= opsize_out_d;
            addr1_out_q  <= addr1_out_d;
            addr2_out_q  <= addr2_out_d;
            rw1_out_q    <= rw1_out_d;
            rw2_out_q    <= rw2_out_d;
            rem_out_q    <= rem_out_d;
            last_out_q   <= last_out_d;
            zero_out_q   <= zero_out_d;
            tag_out_q    <= tag_out_d;
        end
    end

    assign valid_out      = valid_out_q;
    assign opsize_out     = opsize_out_q;
    assign mem_addr1_out  = addr1_out_q;
    assign mem_addr2_out  = addr2_out_q;
    assign mem1_rw_out    = rw1_out_q;
    assign mem2_rw_out    = rw2_out_q;
    assign rem_count_out  = rem_out_q;
    assign last_out       = last_out_q;
    assign zero_iter_out  = zero_out_q;
    assign inst_ptcid_out = tag_out_q;

endmodule

// File: tb/tb_rep_sequencer.sv
// Scoreboard bench for rep_sequencer: directed instructions push expected
// micro-ops; a negedge monitor pops and compares each accepted output.
module tb_rep_sequencer;

    logic        clk;
    logic        clr;
    logic        flush;
    logic        valid_in;
    logic        rep_in;
    logic        df_in;
    logic [1:0]  opsize_in;
    logic [31:0] mem_addr1_in;
    logic [31:0] mem_addr2_in;
    logic [1:0]  mem1_rw_in;
    logic [1:0]  mem2_rw_in;
    logic [31:0] rep_num_in;
    logic [6:0]  inst_ptcid_in;
    logic        stall_in;
    logic        stall_out;
    logic        valid_out;
    logic [1:0]  opsize_out;
    logic [31:0] mem_addr1_out;
    logic [31:0] mem_addr2_out;
    logic [1:0]  mem1_rw_out;
    logic [1:0]  mem2_rw_out;
    logic [31:0] rem_count_out;
    logic        last_out;
    logic        zero_iter_out;
    logic [6:0]  inst_ptcid_out;

    typedef struct {
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] rem;
        logic        last;
        logic        zero;
        logic [1:0]  rw1;
        logic [1:0]  rw2;
        logic [1:0]  op;
        logic [6:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    rep_sequencer #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk            (clk),
        .clr            (clr),
        .flush          (flush),
        .valid_in       (valid_in),
        .rep_in         (rep_in),
        .df_in          (df_in),
        .opsize_in      (opsize_in),
        .mem_addr1_in   (mem_addr1_in),
        .mem_addr2_in   (mem_addr2_in),
        .mem1_rw_in     (mem1_rw_in),
        .mem2_rw_in     (mem2_rw_in),
        .rep_num_in     (rep_num_in),
        .inst_ptcid_in  (inst_ptcid_in),
        .stall_in       (stall_in),
        .stall_out      (stall_out),
        .valid_out      (valid_out),
        .opsize_out     (opsize_out),
        .mem_addr1_out  (mem_addr1_out),
        .mem_addr2_out  (mem_addr2_out),
        .mem1_rw_out    (mem1_rw_out),
        .mem2_rw_out    (mem2_rw_out),
        .rem_count_out  (rem_count_out),
        .last_out       (last_out),
        .zero_iter_out  (zero_iter_out),
        .inst_ptcid_out (inst_ptcid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] rem,
                        input logic last, input logic zero, input logic [1:0] rw1,
                        input logic [1:0] rw2, input logic [1:0] op, input logic [6:0] tag);
        exp_t e;
        e.a1 = a1; e.a2 = a2; e.rem = rem; e.last = last; e.zero = zero;
        e.rw1 = rw1; e.rw2 = rw2; e.op = op; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic rep, input logic df, input logic [1:0] op,
                         input logic [31:0] a1, input logic [31:0] a2, input logic [1:0] rw1,
                         input logic [1:0] rw2, input logic [31:0] num, input logic [6:0] tag);
        valid_in      = 1'b1;
        rep_in        = rep;
        df_in         = df;
        opsize_in     = op;
        mem_addr1_in  = a1;
        mem_addr2_in  = a2;
        mem1_rw_in    = rw1;
        mem2_rw_in    = rw2;
        rep_num_in    = num;
        inst_ptcid_in = tag;
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    // Monitor: downstream consumes an output when valid_out is high and it is not stalling.
    always @(negedge clk) begin
        if (!clr && valid_out && !stall_in) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {32'd0, mem_addr1_out}, 64'hDEAD_BEEF_0000_0000);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("addr1", 64'(mem_addr1_out), 64'(e.a1));
                chk("addr2", 64'(mem_addr2_out), 64'(e.a2));
                chk("rem_count", 64'(rem_count_out), 64'(e.rem));
                chk("last", 64'(last_out), 64'(e.last));
                chk("zero_iter", 64'(zero_iter_out), 64'(e.zero));
                chk("mem1_rw", 64'(mem1_rw_out), 64'(e.rw1));
                chk("mem2_rw", 64'(mem2_rw_out), 64'(e.rw2));
                chk("opsize", 64'(opsize_out), 64'(e.op));
                chk("tag", 64'(inst_ptcid_out), 64'(e.tag));
            end
        end
    end

    initial begin
        clr = 1'b1; flush = 1'b0; stall_in = 1'b1;
        drive(1'b1, 1'b0, 2'b11, 32'hAAAA_0000, 32'hBBBB_0000, 2'b11, 2'b11, 32'd5, 7'h7F);
        to_pos();
        to_pos();
        @(negedge clk);
        chk("reset_valid_out", 64'(valid_out), 64'd0);
        chk("reset_addr1", 64'(mem_addr1_out), 64'd0);
        chk("reset_rem", 64'(rem_count_out), 64'd0);
        chk("reset_last", 64'(last_out), 64'd0);
        chk("reset_tag", 64'(inst_ptcid_out), 64'd0);
        chk("reset_stall_out_masked", 64'(stall_out), 64'd0);
        to_pos();
        clr = 1'b0; stall_in = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        chk("idle_valid_out", 64'(valid_out), 64'd0);
        to_pos();

        // Non-REP pass-through
        drive(1'b0, 1'b0, 2'b10, 32'h1000, 32'h1100, 2'b01, 2'b10, 32'd7, 7'h05);
        push(32'h1000, 32'h1100, 32'd0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 7'h05);
        @(negedge clk);
        chk("nonrep_stall_out", 64'(stall_out), 64'd0);
        to_pos();
        valid_in = 1'b0;
        @(negedge clk);
        chk("nonrep_valid_out", 64'(valid_out), 64'd1);
        to_pos();
        @(negedge clk);
        chk("nonrep_done_valid", 64'(valid_out), 64'd0);
        to_pos();

        // REP count 3, incrementing by 2
        drive(1'b1, 1'b0, 2'b01, 32'h2000, 32'h3000, 2'b01, 2'b10, 32'd3, 7'h11);
        push(32'h2000, 32'h3000, 32'd2, 1'b0, 1'b0, 2'b01, 2'b10, 2'b01, 7'h11);
        push(32'h2002, 32'h3002, 32'd1, 1'b0, 1'b0, 2'b01, 2'b10, 2'b01, 7'h11);
        push(32'h2004, 32'h3004, 32'd0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b01, 7'h11);
        @(negedge clk);
        chk("rep3_stall_accept", 64'(stall_out), 64'd1);
        to_pos();
        valid_in = 1'b0;
        @(negedge clk);
        chk("rep3_stall_op1", 64'(stall_out), 64'd1);
        to_pos();
        @(negedge clk);
        chk("rep3_stall_op2", 64'(stall_out), 64'd1);
        to_pos();
        @(negedge clk);
        chk("rep3_stall_op3", 64'(stall_out), 64'd0);
        to_pos();
        @(negedge clk);
        chk("rep3_done_valid", 64'(valid_out), 64'd0);
        to_pos();

        // REP count 2, decrementing by 8 across zero
        drive(1'b1, 1'b1, 2'b11, 32'h0000_0004, 32'h0000_0100, 2'b10, 2'b01, 32'd2, 7'h22);
        push(32'h0000_0004, 32'h0000_0100, 32'd1, 1'b0, 1'b0, 2'b10, 2'b01, 2'b11, 7'h22);
        push(32'hFFFF_FFFC, 32'h0000_00F8, 32'd0, 1'b1, 1'b0, 2'b10, 2'b01, 2'b11, 7'h22);
        to_pos();
        valid_in = 1'b0;
        to_pos();
        to_pos();

        // REP count 0: single suppressed op
        drive(1'b1, 1'b0, 2'b00, 32'h40, 32'h50, 2'b11, 2'b11, 32'd0, 7'h33);
        push(32'h40, 32'h50, 32'd0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 7'h33);
        @(negedge clk);
        chk("rep0_stall_out", 64'(stall_out), 64'd0);
        to_pos();
        valid_in = 1'b0;
        @(negedge clk);
        chk("rep0_valid_out", 64'(valid_out), 64'd1);
        to_pos();
        @(negedge clk);
        chk("rep0_done_valid", 64'(valid_out), 64'd0);
        to_pos();

        // REP count 4 with a two-cycle downstream stall mid-expansion
        drive(1'b1, 1'b0, 2'b10, 32'h500, 32'h600, 2'b01, 2'b10, 32'd4, 7'h44);
        push(32'h500, 32'h600, 32'd3, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 7'h44);
        push(32'h504, 32'h604, 32'd2, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 7'h44);
        push(32'h508, 32'h608, 32'd1, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 7'h44);
        push(32'h50C, 32'h60C, 32'd0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 7'h44);
        to_pos();
        valid_in = 1'b0;
        to_pos();
        to_pos();
        stall_in = 1'b1;
        @(negedge clk);
        chk("stall_hold_addr1_c1", 64'(mem_addr1_out), 64'h508);
        chk("stall_out_during_stall", 64'(stall_out), 64'd1);
        to_pos();
        @(negedge clk);
        chk("stall_hold_addr1_c2", 64'(mem_addr1_out), 64'h508);
        chk("stall_hold_rem_c2", 64'(rem_count_out), 64'd1);
        to_pos();
        stall_in = 1'b0;
        to_pos();
        to_pos();
        @(negedge clk);
        chk("rep4_done_valid", 64'(valid_out), 64'd0);
        to_pos();

        // REP count 5 flushed after two micro-ops, then a normal non-REP
        drive(1'b1, 1'b0, 2'b00, 32'h700, 32'h800, 2'b01, 2'b10, 32'd5, 7'h55);
        push(32'h700, 32'h800, 32'd4, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 7'h55);
        push(32'h701, 32'h801, 32'd3, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 7'h55);
        to_pos();
        valid_in = 1'b0;
        to_pos();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall_out_masked", 64'(stall_out), 64'd0);
        to_pos();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid_out", 64'(valid_out), 64'd0);
        chk("flush_state_idle", 64'(stall_out), 64'd0);
        drive(1'b0, 1'b1, 2'b01, 32'h900, 32'hA00, 2'b10, 2'b01, 32'd9, 7'h66);
        push(32'h900, 32'hA00, 32'd0, 1'b1, 1'b0, 2'b10, 2'b01, 2'b01, 7'h66);
        to_pos();
        valid_in = 1'b0;
        to_pos();
        to_pos();
        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
